// File: rtl/dmem_responder_if.sv
// Core <-> data-memory responder bus: one request channel, one response channel.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding RV32I data memory responder with configurable access latency.
// Word-organized array with byte-lane write enables; loads are extended per funct3.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;

  logic          accept;
  logic          req_legal_f3, req_misaligned, req_oor, req_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_result;

  // Requests are only taken in IDLE and never while reset is held.
  assign bus.req_ready = (state_q == ST_IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state_q != ST_IDLE);

  // Classify the incoming request: illegal code, misalignment, or past the array end.
  always_comb begin
    req_legal_f3 = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: req_legal_f3 = 1'b1;
      3'b100, 3'b101:         req_legal_f3 = !bus.req_write;
      default:                req_legal_f3 = 1'b0;
    endcase
    req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_oor        = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
    req_err        = !req_legal_f3 || req_misaligned || req_oor;
  end

  // Load path: pick the addressed lane from the word and extend it.
  always_comb begin
    rd_word = mem_q[addr_q[AW+1:2]];
    rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_q)
      3'b000:  load_result = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_result = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_result = {24'h0, rd_byte};
      3'b101:  load_result = {16'h0, rd_half};
      default: load_result = rd_word;
    endcase
  end

  // Store path: replicate the data across lanes and enable only the addressed bytes.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_q;
      end
    endcase
  end

  // Transaction FSM: accept in IDLE, count down in WAIT, hold the response in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr[AW+1:0];
          wdata_d  = bus.req_wdata;
          if (req_err) begin
            // Rejected requests skip the access entirely and answer immediately.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          if (write_q) begin
            mem_we       = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            resp_rdata_d = load_result;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array write; contents survive reset, but a store aborted by reset never lands.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-addressed reference model plus literal checks.
module tb_dmem_responder;
  localparam int W     = 1;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  bit   started = 1'b0;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (byte memory, edge-count latency) ----------------
  logic [7:0]  mb [0:4*DEPTH-1];
  bit          m_busy = 1'b0;
  int          m_left = 0;
  bit          e_valid = 1'b0;
  logic [31:0] e_rdata = 32'h0;
  bit          e_err = 1'b0;
  bit          t_w = 1'b0;
  logic [31:0] t_a = 32'h0;
  logic [31:0] t_d = 32'h0;
  logic [2:0]  t_f = 3'b0;

  function automatic bit m_is_err(input bit w, input logic [31:0] a, input logic [2:0] f);
    bit legal;
    legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    if (!legal) return 1'b1;
    if ((f == 3'd1 || f == 3'd5) && a[0]) return 1'b1;
    if (f == 3'd2 && (a % 4) != 0) return 1'b1;
    return (a / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f);
    case (f)
      3'd0:    return {{24{mb[a][7]}}, mb[a]};
      3'd1:    return {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
      3'd4:    return {24'h0, mb[a]};
      3'd5:    return {16'h0, mb[a+1], mb[a]};
      default: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endcase
  endfunction

  // Response appears W+1 edges after a legal accept, on the accept edge for an error.
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_left <= 0; e_valid <= 1'b0; e_rdata <= 32'h0; e_err <= 1'b0;
    end else if (e_valid) begin
      if (bus.resp_ready) begin
        e_valid <= 1'b0; e_rdata <= 32'h0; e_err <= 1'b0; m_busy <= 1'b0;
      end
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
    end else if (m_left == 1) begin
      m_left  <= 0;
      e_valid <= 1'b1;
      e_err   <= 1'b0;
      if (t_w) begin
        e_rdata <= 32'h0;
        mb[t_a] <= t_d[7:0];
        if (t_f != 3'd0) mb[t_a+1] <= t_d[15:8];
        if (t_f == 3'd2) begin
          mb[t_a+2] <= t_d[23:16];
          mb[t_a+3] <= t_d[31:24];
        end
      end else begin
        e_rdata <= m_load(t_a, t_f);
      end
    end else if (!m_busy && bus.req_valid) begin
      m_busy <= 1'b1;
      t_w <= bus.req_write; t_a <= bus.req_addr; t_d <= bus.req_wdata; t_f <= bus.req_funct3;
      if (m_is_err(bus.req_write, bus.req_addr, bus.req_funct3)) begin
        e_valid <= 1'b1; e_err <= 1'b1; e_rdata <= 32'h0;
      end else begin
        m_left <= W + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    #2;
    if (started) begin
      chk("cmp_resp_valid", 32'(bus.resp_valid), 32'(e_valid));
      chk("cmp_resp_rdata", bus.resp_rdata, e_rdata);
      chk("cmp_resp_err", 32'(bus.resp_err), 32'(e_err));
      chk("cmp_req_ready", 32'(bus.req_ready), 32'(!m_busy && !reset));
      chk("cmp_busy", 32'(busy), 32'(m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  // One transaction; while the responder is busy, junk requests are presented and must be ignored.
  task automatic do_txn(input string name, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic [31:0] xr, input bit xe,
                        input int hold, output int acc);
    int lat;
    logic [31:0] r0;
    wait_ready();
    bus.resp_ready = (hold == 0);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_funct3 = f;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0;
      bus.req_wdata = $urandom; bus.req_funct3 = 3'd2;
      @(negedge clk);
      lat++;
    end
    bus.req_valid = 1'b0;
    chk({name, "_latency"}, 32'(lat), xe ? 32'd0 : 32'(W + 1));
    chk({name, "_rdata"}, bus.resp_rdata, xr);
    chk({name, "_err"}, 32'(bus.resp_err), 32'(xe));
    r0 = bus.resp_rdata;
    repeat (hold) begin
      @(negedge clk);
      chk({name, "_hold_rdata"}, bus.resp_rdata, r0);
      chk({name, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({name, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk({name, "_done_valid"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    int a0, a1, n;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_funct3 = 3'd0; bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_low", 32'(bus.req_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_txn("sw_0", 1, 32'h00, 32'h01020304, 3'd2, 32'h0, 0, 0, a0);
    do_txn("sw_10", 1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 0, 0, a0);
    do_txn("lw_10", 0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 0, 0, a0);
    do_txn("lb_13", 0, 32'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 0, 0, a0);
    do_txn("lbu_13", 0, 32'h13, 32'h0, 3'd4, 32'h000000DE, 0, 0, a1);
    chk("throughput", 32'(a1 - a0), 32'(W + 3));
    do_txn("lh_12", 0, 32'h12, 32'h0, 3'd1, 32'hFFFFDEAD, 0, 0, a0);
    do_txn("lhu_10", 0, 32'h10, 32'h0, 3'd5, 32'h0000BEEF, 0, 0, a0);
    do_txn("sb_11", 1, 32'h11, 32'hAAAAAA55, 3'd0, 32'h0, 0, 0, a0);
    do_txn("lw_10b", 0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0, 0, a0);
    do_txn("sw_14", 1, 32'h14, 32'h11223344, 3'd2, 32'h0, 0, 0, a0);
    do_txn("sh_16", 1, 32'h16, 32'hFFFFABCD, 3'd1, 32'h0, 0, 0, a0);
    do_txn("lw_14", 0, 32'h14, 32'h0, 3'd2, 32'hABCD3344, 0, 0, a0);
    do_txn("lh_16", 0, 32'h16, 32'h0, 3'd1, 32'hFFFFABCD, 0, 0, a0);
    do_txn("lhu_16", 0, 32'h16, 32'h0, 3'd5, 32'h0000ABCD, 0, 0, a0);

    // Rejected requests
    do_txn("lw_mis", 0, 32'h12, 32'h0, 3'd2, 32'h0, 1, 0, a0);
    do_txn("lh_mis", 0, 32'h11, 32'h0, 3'd1, 32'h0, 1, 0, a0);
    do_txn("sw_oor", 1, 32'h1000, 32'hBADBAD00, 3'd2, 32'h0, 1, 0, a0);
    do_txn("lw_0", 0, 32'h00, 32'h0, 3'd2, 32'h01020304, 0, 0, a0);
    do_txn("ld_f3_011", 0, 32'h10, 32'h0, 3'd3, 32'h0, 1, 0, a0);
    do_txn("ld_f3_110", 0, 32'h10, 32'h0, 3'd6, 32'h0, 1, 0, a0);
    do_txn("st_f3_100", 1, 32'h10, 32'h0, 3'd4, 32'h0, 1, 0, a0);

    // Back-pressure on the response
    do_txn("lw_hold", 0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0, 5, a0);

    // Reset during WAIT aborts the store
    do_txn("sw_20", 1, 32'h20, 32'hCAFEF00D, 3'd2, 32'h0, 0, 0, a0);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h12345678; bus.req_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(bus.resp_valid), 32'd0);
    end
    do_txn("lw_20", 0, 32'h20, 32'h0, 3'd2, 32'hCAFEF00D, 0, 0, a0);

    // Reset during RESP discards the pending response
    wait_ready();
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10; bus.req_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rr_resp_seen", 32'(bus.resp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("rr_valid_dropped", 32'(bus.resp_valid), 32'd0);
    chk("rr_idle", 32'(busy), 32'd0);
    do_txn("lw_after_rr", 0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0, 0, a0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
